alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Fully pipelined, parametrised integer ALU. It is the throughput successor to the team's 5-cycle, one-op-at-a-time multi-cycle ALU.
- Accepts one operation per cycle through a valid/ready handshake and returns results in order after a fixed 3-cycle latency. Bubbles collapse.
- Generalises data width, adds a pass-through tag, result flags and six further operations: XOR, SRA, SLT, SLTU, CLZ, MIN/MAX.
- Sits between the issue logic and writeback in the execute cluster.

Parameters:
- WIDTH, 64, operand/result width; power of two, 8..128.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  operation offered.
- in_ready  output  1  ALU can accept an operation this cycle.
- in_op  input  4  operation select (encoding below).
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_tag  input  TAG_W  tag, returned unchanged.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_z  output  WIDTH  result.
- out_tag  output  TAG_W  tag of the result.
- out_zero  output  1  out_z == 0.
- out_carry  output  1  carry/borrow flag.
- inflight  output  2  number of occupied pipeline stages (0..3).

Behaviour:
- Ops:
  - 0 AND, 1 OR, 2 XOR, 3 NOT a.
  - 4 ADD, 5 SUB (a-b), 6 INC (a+1).
  - 7 SLL, 8 SRL, 9 SRA; shift amount is b[$clog2(WIDTH)-1:0].
  - A SLT (signed), B SLTU; result is 1 or 0, zero-extended.
  - C POPCNT a, D CLZ a (CLZ of 0 = WIDTH).
  - E MIN signed, F MAX signed.
- Carry:
  - ADD: carry-out of a+b.
  - SUB: 1 when a<b unsigned (borrow).
  - INC: 1 when a is all ones.
  - All other ops: 0.
- All arithmetic is modulo 2^WIDTH. Count results are zero-extended to WIDTH.
- Pipeline: S1 registers operands/op/tag; S2 computes result and flags; S3 is the output register driving out_*. Each stage has a valid bit v1..v3.
- Handshake:
  - A transfer occurs when valid && ready are both high at a rising edge.
  - in_ready = !v1 || !v2 || !v3 || out_ready, combinational. A bubble anywhere lets upstream stages advance.
  - Stage i advances when !v(i+1) or stage i+1 advances; S3 empties when out_ready.
  - out_valid = v3. out_* hold stable while out_valid && !out_ready.
- Latency: an op accepted at edge N is visible on out_* in the cycle after edge N+2 when no stall. Throughput is 1 op/cycle.
- Ordering: results are strictly in acceptance order; no drops or duplicates under any out_ready pattern.
- inflight = v1+v2+v3, registered.
- Reset (rst_n low, any time including mid-operation):
  - All valid bits clear immediately; in-flight ops are discarded.
  - out_valid=0, out_z=0, out_tag=0, out_zero=0, out_carry=0, inflight=0.
  - in_ready is 1 on the first cycle after deassertion.
- Data registers need not be reset, but out_* must read 0 while out_valid=0 after reset.
- Boundaries:
  - Full (3 ops held, out_ready=0): in_ready=0 and in_valid is ignored.
  - Simultaneous out_ready and in_valid when full: the accept happens the same cycle.
  - Shift amount ≥ the meaningful range is impossible by masking.
  - SRA replicates a[WIDTH-1].

Test Plan:
- Reset mid-stream: 3 ops in flight, pull rst_n low for 1 cycle → out_valid=0 and inflight=0 immediately; the first op after release emerges alone.
- Basic latency, WIDTH=64: ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1, tag=5 → 3 cycles later out_z=0, out_zero=1, out_carry=1, out_tag=5.
- Op sweep, WIDTH=8:
  - SRA a=0x80, b=0x03 → 0xF0.
  - SLT a=0xFF, b=0x01 → 1.
  - SLTU a=0xFF, b=0x01 → 0.
  - CLZ a=0 → 8.
  - POPCNT a=0xB5 → 5.
  - MIN a=0x80, b=0x7F → 0x80.
- Back-to-back: 16 ops (one of each opcode) on consecutive cycles, out_ready=1 → 16 results on 16 consecutive cycles, tags 0..15 in order.
- Backpressure: stream with out_ready=0 for 5 cycles → in_ready falls after 3 accepts, inflight=3, out_* stable; on release, all results arrive in order with none lost.
- Bubble collapse: accept op A, out_ready=0, idle 2 cycles, then offer B → B accepted (in_ready=1) while A is held; inflight=2.

Source files
------------

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - three-stage pipelined integer ALU with valid/ready handshake
module alu_pipe #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_carry,
    output logic [1:0]       inflight
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [3:0]       op1_q, op1_d;
    logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
    logic [WIDTH-1:0] z2_q, z2_d, z3_q, z3_d;
    logic             zero2_q, zero2_d, zero3_q, zero3_d;
    logic             carry2_q, carry2_d, carry3_q, carry3_d;
    logic [1:0]       inflight_q, inflight_d;

    logic             s1_free, s2_free, s3_free;
    logic [WIDTH-1:0] res;
    logic             res_carry;
    logic [WIDTH:0]   sum;
    logic [CNT_W-1:0] pop, clz;
    logic             found, lt_s, lt_u;
    logic [SH_W-1:0]  sh;

    // A stage can take new contents when it is empty or its contents move on.
    always_comb begin
        s3_free  = !v3_q || out_ready;
        s2_free  = !v2_q || s3_free;
        s1_free  = !v1_q || s2_free;
        in_ready = s1_free;
    end

    always_comb begin
        res       = '0;
        res_carry = 1'b0;
        sh        = b1_q[SH_W-1:0];
        sum       = {1'b0, a1_q} + {1'b0, b1_q};
        lt_s      = $signed(a1_q) < $signed(b1_q);
        lt_u      = a1_q < b1_q;
        pop       = '0;
        clz       = '0;
        found     = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + CNT_W'(a1_q[i]);
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (a1_q[i]) found = 1'b1;
                else         clz   = clz + 1'b1;
            end
        end
        case (op1_q)
            4'h0: res = a1_q & b1_q;
            4'h1: res = a1_q | b1_q;
            4'h2: res = a1_q ^ b1_q;
            4'h3: res = ~a1_q;
            4'h4: begin res = sum[WIDTH-1:0]; res_carry = sum[WIDTH]; end
            4'h5: begin res = a1_q - b1_q;    res_carry = lt_u;      end
            4'h6: begin res = a1_q + 1'b1;    res_carry = &a1_q;     end
            4'h7: res = a1_q << sh;
            4'h8: res = a1_q >> sh;
            4'h9: res = $signed(a1_q) >>> sh;
            4'hA: res = {{(WIDTH-1){1'b0}}, lt_s};
            4'hB: res = {{(WIDTH-1){1'b0}}, lt_u};
            4'hC: res = {{(WIDTH-CNT_W){1'b0}}, pop};
            4'hD: res = {{(WIDTH-CNT_W){1'b0}}, clz};
            4'hE: res = lt_s ? a1_q : b1_q;
            4'hF: res = lt_s ? b1_q : a1_q;
        endcase
    end

    always_comb begin
        v1_d = v1_q; op1_d = op1_q; a1_d = a1_q; b1_d = b1_q; tag1_d = tag1_q;
        v2_d = v2_q; z2_d = z2_q; tag2_d = tag2_q; zero2_d = zero2_q; carry2_d = carry2_q;
        v3_d = v3_q; z3_d = z3_q; tag3_d = tag3_q; zero3_d = zero3_q; carry3_d = carry3_q;
        if (s1_free) begin
            v1_d = in_valid; op1_d = in_op; a1_d = in_a; b1_d = in_b; tag1_d = in_tag;
        end
        if (s2_free) begin
            v2_d = v1_q; z2_d = res; tag2_d = tag1_q;
            zero2_d = (res == '0); carry2_d = res_carry;
        end
        if (s3_free) begin
            v3_d = v2_q; z3_d = z2_q; tag3_d = tag2_q;
            zero3_d = zero2_q; carry3_d = carry2_q;
        end
        inflight_d = {1'b0, v1_d} + {1'b0, v2_d} + {1'b0, v3_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0; op1_q <= '0; a1_q <= '0; b1_q <= '0; tag1_q <= '0;
            v2_q <= 1'b0; z2_q <= '0; tag2_q <= '0; zero2_q <= 1'b0; carry2_q <= 1'b0;
            v3_q <= 1'b0; z3_q <= '0; tag3_q <= '0; zero3_q <= 1'b0; carry3_q <= 1'b0;
            inflight_q <= '0;
        end else begin
            v1_q <= v1_d; op1_q <= op1_d; a1_q <= a1_d; b1_q <= b1_d; tag1_q <= tag1_d;
            v2_q <= v2_d; z2_q <= z2_d; tag2_q <= tag2_d; zero2_q <= zero2_d; carry2_q <= carry2_d;
            v3_q <= v3_d; z3_q <= z3_d; tag3_q <= tag3_d; zero3_q <= zero3_d; carry3_q <= carry3_d;
            inflight_q <= inflight_d;
        end
    end

    // Outputs read as zero whenever no result is presented.
    always_comb begin
        out_valid = v3_q;
        out_z     = v3_q ? z3_q : '0;
        out_tag   = v3_q ? tag3_q : '0;
        out_zero  = v3_q && zero3_q;
        out_carry = v3_q && carry3_q;
        inflight  = inflight_q;
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe with random and directed stimulus
module tb_alu_pipe;
    typedef struct packed {
        logic [7:0] z;
        logic [3:0] tag;
        logic       zero;
        logic       carry;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_zero, out_carry;
    logic [3:0]  in_op, in_tag, out_tag;
    logic [7:0]  in_a, in_b, out_z;
    logic [1:0]  inflight;

    logic        in_valid64, in_ready64, out_valid64, out_ready64, out_zero64, out_carry64;
    logic [3:0]  in_op64, in_tag64, out_tag64;
    logic [63:0] in_a64, in_b64, out_z64;
    logic [1:0]  inflight64;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    res_t exp_q[$];
    int   out_cyc[$];

    alu_pipe #(.WIDTH(8), .TAG_W(4)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_tag(out_tag),
        .out_zero(out_zero), .out_carry(out_carry), .inflight(inflight)
    );

    alu_pipe #(.WIDTH(64), .TAG_W(4)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
        .in_op(in_op64), .in_a(in_a64), .in_b(in_b64), .in_tag(in_tag64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_z(out_z64), .out_tag(out_tag64),
        .out_zero(out_zero64), .out_carry(out_carry64), .inflight(inflight64)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference behaviour for a w-bit ALU, using wide unsigned arithmetic and masks.
    function automatic void model(input int w, input logic [3:0] op, input logic [127:0] a,
                                  input logic [127:0] b, output logic [127:0] z, output logic c);
        logic [127:0] mask, sb, t;
        int sh, n;
        mask = (128'd1 << w) - 128'd1;
        sb   = 128'd1 << (w - 1);
        sh   = int'(b % 128'(w));
        c    = 1'b0;
        z    = '0;
        case (op)
            4'h0: z = a & b;
            4'h1: z = a | b;
            4'h2: z = a ^ b;
            4'h3: z = ~a & mask;
            4'h4: begin t = a + b; z = t & mask; c = t[w]; end
            4'h5: begin z = (a - b) & mask; c = a < b; end
            4'h6: begin z = (a + 128'd1) & mask; c = (a == mask); end
            4'h7: z = (a << sh) & mask;
            4'h8: z = a >> sh;
            4'h9: z = (a & sb) != 0 ? ((a >> sh) | (mask & ~(mask >> sh))) : (a >> sh);
            4'hA: z = 128'((a ^ sb) < (b ^ sb));
            4'hB: z = 128'(a < b);
            4'hC: begin n = 0; t = a; while (t != 0) begin n += int'(t[0]); t = t >> 1; end z = 128'(n); end
            4'hD: begin n = 0; while (n < w && (a >> n) != 0) n++; z = 128'(w - n); end
            4'hE: z = ((a ^ sb) < (b ^ sb)) ? a : b;
            4'hF: z = ((a ^ sb) < (b ^ sb)) ? b : a;
        endcase
    endfunction

    // Scoreboard: record accepted ops, compare every delivered result in order.
    initial begin
        logic [127:0] mz;
        logic         mc;
        res_t         e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    out_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_output: got tag %0h, expected no result", out_tag);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result{z,tag,zero,carry}", 128'({out_z, out_tag, out_zero, out_carry}), 128'(e));
                    end
                end
                if (in_valid && in_ready) begin
                    model(8, in_op, 128'(in_a), 128'(in_b), mz, mc);
                    e.z = mz[7:0]; e.tag = in_tag; e.zero = (mz[7:0] == 8'h00); e.carry = mc;
                    exp_q.push_back(e);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields(input logic [3:0] tag);
        in_op  = 4'($urandom);
        in_a   = 8'($urandom);
        in_b   = 8'($urandom);
        in_tag = tag;
    endtask

    task automatic send8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] tag);
        logic acc;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            #1;
            acc = in_ready;
            tick();
        end
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int t = 0; t < 30 && !(exp_q.size() == 0 && !out_valid); t++) tick();
        chk("drain_empty", 128'(exp_q.size()), 0);
    endtask

    task automatic dir8(input string nm, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] ez, input logic ec);
        logic got;
        out_ready = 1'b1;
        send8(op, a, b, 4'hA);
        in_valid = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            if (out_valid) got = 1'b1;
            else tick();
        end
        if (!got) chk({nm, "_timeout"}, 0, 1);
        else      chk(nm, 128'({out_z, out_carry}), 128'({ez, ec}));
        tick();
    endtask

    initial begin
        int   base, acc_n;
        logic ok, held;
        logic [7:0] held_z;
        logic [3:0] held_tag;

        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
        in_valid64 = 1'b0; in_op64 = '0; in_a64 = '0; in_b64 = '0; in_tag64 = '0; out_ready64 = 1'b1;
        repeat (3) tick();
        chk("rst_outputs8", 128'({out_valid, out_z, out_tag, out_zero, out_carry, inflight}), 0);
        chk("rst_outputs64", 128'({out_valid64, out_z64, out_tag64, out_zero64, out_carry64, inflight64}), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 128'({in_ready, in_ready64}), 128'(2'b11));

        // 64-bit ADD wrap: exact 3-cycle latency and flags.
        in_valid64 = 1'b1; in_op64 = 4'h4; in_a64 = '1; in_b64 = 64'd1; in_tag64 = 4'd5;
        tick();
        in_valid64 = 1'b0;
        chk("lat64_edge0", 128'(out_valid64), 0);
        tick();
        chk("lat64_edge1", 128'(out_valid64), 0);
        tick();
        chk("lat64_result", 128'({out_valid64, out_z64, out_zero64, out_carry64, out_tag64}),
            128'({1'b1, 64'd0, 1'b1, 1'b1, 4'd5}));
        tick();
        chk("lat64_gone", 128'(out_valid64), 0);

        dir8("sra", 4'h9, 8'h80, 8'h03, 8'hF0, 1'b0);
        dir8("slt", 4'hA, 8'hFF, 8'h01, 8'h01, 1'b0);
        dir8("sltu", 4'hB, 8'hFF, 8'h01, 8'h00, 1'b0);
        dir8("clz0", 4'hD, 8'h00, 8'h00, 8'h08, 1'b0);
        dir8("popcnt", 4'hC, 8'hB5, 8'h00, 8'h05, 1'b0);
        dir8("min", 4'hE, 8'h80, 8'h7F, 8'h80, 1'b0);
        dir8("sll_mask", 4'h7, 8'h01, 8'hFF, 8'h80, 1'b0);
        dir8("inc_wrap", 4'h6, 8'hFF, 8'h00, 8'h00, 1'b1);
        dir8("sub_borrow", 4'h5, 8'h01, 8'h02, 8'hFF, 1'b1);
        drain();

        // Back-to-back: one op per opcode, tags 0..15.
        base = out_cyc.size();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send8(4'(i), 8'($urandom), 8'($urandom), 4'(i));
        in_valid = 1'b0;
        repeat (6) tick();
        chk("b2b_count", 128'(out_cyc.size() - base), 16);
        if (out_cyc.size() - base == 16) chk("b2b_consecutive", 128'(out_cyc[base+15] - out_cyc[base]), 15);
        drain();

        // Backpressure: 5 cycles offered with out_ready low.
        base = out_cyc.size();
        out_ready = 1'b0; in_valid = 1'b1; rand_fields(4'd0);
        acc_n = 0; held = 1'b0; held_z = '0; held_tag = '0;
        for (int k = 0; k < 5; k++) begin
            #1;
            ok = in_ready;
            tick();
            if (ok) begin acc_n++; rand_fields(4'(acc_n)); end
            if (out_valid && !held) begin held = 1'b1; held_z = out_z; held_tag = out_tag; end
        end
        chk("bp_accepts", 128'(acc_n), 3);
        chk("bp_full", 128'({in_ready, inflight, out_valid}), 128'({1'b0, 2'd3, 1'b1}));
        chk("bp_stable", 128'({held, out_z, out_tag}), 128'({1'b1, held_z, held_tag}));
        out_ready = 1'b1;
        #1;
        chk("bp_full_accept", 128'(in_ready), 1);
        tick();
        drain();
        chk("bp_delivered", 128'(out_cyc.size() - base), 4);

        // Bubble collapse.
        out_ready = 1'b0;
        send8(4'h1, 8'h0F, 8'hF0, 4'd1);
        in_valid = 1'b0;
        tick();
        tick();
        chk("bubble_a_held", 128'({inflight, out_valid}), 128'({2'd1, 1'b1}));
        in_valid = 1'b1; rand_fields(4'd2);
        #1;
        chk("bubble_b_ready", 128'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("bubble_inflight", 128'(inflight), 2);
        drain();

        // Random traffic with random backpressure.
        in_valid = 1'b0; ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || ok) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_fields(4'($urandom));
            end
            #1;
            chk("rand_inflight", 128'(inflight), 128'(exp_q.size()));
            chk("rand_in_ready", 128'(in_ready), 128'(exp_q.size() < 3 || out_ready));
            ok = in_valid && in_ready;
            tick();
        end
        drain();

        // Reset with three ops in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send8(4'h4, 8'($urandom), 8'($urandom), 4'(i + 4));
        in_valid = 1'b0;
        chk("mid_full", 128'(inflight), 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_clear", 128'({out_valid, inflight, out_z}), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_ready", 128'(in_ready), 1);
        base = out_cyc.size();
        out_ready = 1'b1;
        send8(4'h4, 8'd3, 8'd4, 4'd9);
        in_valid = 1'b0;
        repeat (8) tick();
        chk("mid_rst_alone", 128'(out_cyc.size() - base), 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
